// File: rtl/vframe_ctr.sv
// ---------------------------------------------------------------------------
// vframe_ctr -- vertical frame counter for a raster timing generator.
//
// Counts lines on each end-of-line strobe from the horizontal counter and
// walks the vertical phases ACTIVE -> FRONT -> SYNC -> BACK. It also raises
// a CPU frame interrupt on entry to vertical blanking.
//
// Ports
//   clk         in   system clock (shared with the horizontal counter)
//   reset_n     in   asynchronous active-low reset
//   h_end       in   end-of-line strobe, one line per high cycle
//   int_en      in   frame-interrupt enable (gates new assertion only)
//   int_ack     in   CPU interrupt acknowledge, level-sensitive
//   line        out  current line within the frame (0 .. total-1)
//   phase       out  0=ACTIVE 1=FRONT 2=SYNC 3=BACK
//   v_blank     out  high outside ACTIVE
//   v_sync_n    out  low during SYNC
//   frame_start out  one-cycle pulse when line becomes 0
//   v_int_n     out  frame interrupt, active low
//
// State table
//   state     | meaning
//   ST_ACTIVE | visible lines
//   ST_FRONT  | front porch, blanking
//   ST_SYNC   | vertical sync pulse
//   ST_BACK   | back porch, blanking
// ---------------------------------------------------------------------------
module vframe_ctr #(
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       h_end,
  input  logic       int_en,
  input  logic       int_ack,
  output logic [9:0] line,
  output logic [1:0] phase,
  output logic       v_blank,
  output logic       v_sync_n,
  output logic       frame_start,
  output logic       v_int_n
);

  localparam int         TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] LINE_LAST  = 10'(TOTAL - 1);
  localparam logic [9:0] ACT_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] FRONT_LAST = 10'(V_FRONT - 1);
  localparam logic [9:0] SYNC_LAST  = 10'(V_SYNC - 1);
  localparam logic [9:0] BACK_LAST  = 10'(V_BACK - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] ph_cnt, ph_cnt_nxt;
  logic [9:0] line_nxt;
  logic [9:0] ph_last;
  logic       armed;
  logic       adv;
  logic       frame_wrap;
  logic       int_set;

  // Blocks the h_end on the first edge after reset release so counting
  // restarts cleanly from the following strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  assign adv = h_end & armed;

  always_comb begin
    state_nxt  = state;
    ph_cnt_nxt = ph_cnt;
    line_nxt   = line;
    frame_wrap = 1'b0;
    int_set    = 1'b0;

    case (state)
      ST_ACTIVE: ph_last = ACT_LAST;
      ST_FRONT:  ph_last = FRONT_LAST;
      ST_SYNC:   ph_last = SYNC_LAST;
      default:   ph_last = BACK_LAST;
    endcase

    if (adv) begin
      // The >= also recovers any out-of-range line back to the frame top.
      if (line >= LINE_LAST) begin
        line_nxt   = 10'd0;
        state_nxt  = ST_ACTIVE;
        ph_cnt_nxt = 10'd0;
        frame_wrap = 1'b1;
      end else begin
        line_nxt = line + 10'd1;
        if (ph_cnt >= ph_last) begin
          ph_cnt_nxt = 10'd0;
          case (state)
            ST_ACTIVE: state_nxt = ST_FRONT;
            ST_FRONT:  state_nxt = ST_SYNC;
            ST_SYNC:   state_nxt = ST_BACK;
            default:   state_nxt = ST_ACTIVE;
          endcase
          int_set = (state == ST_ACTIVE) && int_en;
        end else begin
          ph_cnt_nxt = ph_cnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_ACTIVE;
      ph_cnt      <= 10'd0;
      line        <= 10'd0;
      v_blank     <= 1'b0;
      v_sync_n    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      ph_cnt      <= ph_cnt_nxt;
      line        <= line_nxt;
      v_blank     <= (state_nxt != ST_ACTIVE);
      v_sync_n    <= (state_nxt != ST_SYNC);
      frame_start <= frame_wrap;
    end
  end

  // A new set wins over a coincident acknowledge; ack is ignored while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 v_int_n <= 1'b1;
    else if (int_set)             v_int_n <= 1'b0;
    else if (int_ack && !v_int_n) v_int_n <= 1'b1;
  end

  assign phase = state;

endmodule

// File: tb/tb_vframe_ctr.sv
module tb_vframe_ctr;

  localparam int V_ACT = 480;
  localparam int V_FR  = 10;
  localparam int V_SY  = 2;
  localparam int V_BK  = 33;
  localparam int TOTAL = V_ACT + V_FR + V_SY + V_BK;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       h_end;
  logic       int_en;
  logic       int_ack;
  logic [9:0] line;
  logic [1:0] phase;
  logic       v_blank;
  logic       v_sync_n;
  logic       frame_start;
  logic       v_int_n;

  always #5 clk = ~clk;

  vframe_ctr #(
    .V_ACTIVE(V_ACT),
    .V_FRONT (V_FR),
    .V_SYNC  (V_SY),
    .V_BACK  (V_BK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .h_end      (h_end),
    .int_en     (int_en),
    .int_ack    (int_ack),
    .line       (line),
    .phase      (phase),
    .v_blank    (v_blank),
    .v_sync_n   (v_sync_n),
    .frame_start(frame_start),
    .v_int_n    (v_int_n)
  );

  typedef struct packed {
    logic [9:0] line;
    logic [1:0] phase;
    logic       vb;
    logic       vs_n;
    logic       fs;
    logic       irq_n;
  } rec_t;

  typedef struct {
    int start;
    bit h;
    bit en;
    bit ack;
    int e_line;
    int e_phase;
    bit e_irq_n;
    bit e_fs;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t sb_q[$];
  vec_t vt[$];

  function automatic int ref_phase(int ln);
    if (ln < V_ACT)               return 0;
    if (ln < V_ACT + V_FR)        return 1;
    if (ln < V_ACT + V_FR + V_SY) return 2;
    return 3;
  endfunction

  function automatic rec_t mk(int ln, int ph, bit irq_n, bit fs);
    rec_t r;
    r.line  = 10'(ln);
    r.phase = 2'(ph);
    r.vb    = (ph != 0);
    r.vs_n  = (ph != 2);
    r.fs    = fs;
    r.irq_n = irq_n;
    return r;
  endfunction

  task automatic add(int start, bit h, bit en, bit ack, int l, int p, bit irq_n, bit fs);
    vec_t v;
    v.start = start; v.h = h; v.en = en; v.ack = ack;
    v.e_line = l; v.e_phase = p; v.e_irq_n = irq_n; v.e_fs = fs;
    vt.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, rec_t exp);
    rec_t act;
    act.line = line; act.phase = phase; act.vb = v_blank;
    act.vs_n = v_sync_n; act.fs = frame_start; act.irq_n = v_int_n;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got line=%0d phase=%0d vb=%0b vs_n=%0b fs=%0b irq_n=%0b want line=%0d phase=%0d vb=%0b vs_n=%0b fs=%0b irq_n=%0b",
               nm, act.line, act.phase, act.vb, act.vs_n, act.fs, act.irq_n,
               exp.line, exp.phase, exp.vb, exp.vs_n, exp.fs, exp.irq_n);
    end
  endtask

  task automatic sb_pop(string nm);
    rec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      check(nm, e);
    end
  endtask

  task automatic step(bit h, bit en, bit ack, rec_t exp, string nm);
    h_end = h; int_en = en; int_ack = ack;
    sb_q.push_back(exp);
    tick();
    sb_pop(nm);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; h_end = 1'b0; int_en = 1'b0; int_ack = 1'b0;
    tick();
    tick();
    check("reset_state", mk(0, 0, 1'b1, 1'b0));
    reset_n = 1'b1;
    tick();
  endtask

  task automatic advance(int n_lines, bit en);
    bit irq_n = 1'b1;
    for (int n = 1; n <= n_lines; n++) begin
      if (en && n == V_ACT) irq_n = 1'b0;
      step(1'b1, en, 1'b0, mk(n, ref_phase(n), irq_n, 1'b0), "advance");
    end
    h_end = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_seen;
    int ln;

    // start, h, en, ack -> line, phase, irq_n, frame_start
    add(478, 1, 1, 0, 479, 0, 1, 0);
    add(-1,  1, 1, 0, 480, 1, 0, 0);
    add(-1,  0, 1, 0, 480, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(-1, 0, 0, 0, 480, 1, 0, 0);
    add(-1,  0, 0, 1, 480, 1, 1, 0);
    add(-1,  0, 0, 1, 480, 1, 1, 0);
    add(-1,  1, 1, 1, 481, 1, 1, 0);
    add(479, 1, 1, 1, 480, 1, 0, 0);
    add(-1,  0, 1, 0, 480, 1, 0, 0);
    add(-1,  1, 1, 0, 481, 1, 0, 0);
    add(-1,  0, 1, 1, 481, 1, 1, 0);
    add(479, 1, 0, 0, 480, 1, 1, 0);
    add(-1,  1, 0, 1, 481, 1, 1, 0);
    add(489, 1, 0, 0, 490, 2, 1, 0);
    add(-1,  1, 0, 0, 491, 2, 1, 0);
    add(-1,  1, 0, 0, 492, 3, 1, 0);
    add(524, 1, 0, 0, 0,   0, 1, 1);
    add(-1,  0, 0, 0, 0,   0, 1, 0);
    add(10,  1, 0, 0, 11,  0, 1, 0);
    add(-1,  1, 0, 0, 12,  0, 1, 0);
    add(-1,  1, 0, 0, 13,  0, 1, 0);
    add(-1,  0, 0, 0, 13,  0, 1, 0);

    // Full frame, strobes 32 clocks apart.
    do_reset();
    fs_seen = 0;
    for (int n = 1; n <= TOTAL; n++) begin
      ln = n % TOTAL;
      h_end = 1'b1;
      sb_q.push_back(mk(ln, ref_phase(ln), 1'b1, ln == 0));
      tick();
      h_end = 1'b0;
      fs_seen += int'(frame_start);
      sb_pop("frame_step");
      for (int k = 0; k < 30; k++) begin
        tick();
        fs_seen += int'(frame_start);
      end
      check("frame_hold", mk(ln, ref_phase(ln), 1'b1, 1'b0));
      tick();
      fs_seen += int'(frame_start);
    end
    checks++;
    if (fs_seen != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d want 1", fs_seen);
    end

    // Vector table: interrupt handshake, collision, gating, phases, wrap, back-to-back.
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].start >= 0) begin
        do_reset();
        advance(vt[i].start, 1'b0);
      end
      step(vt[i].h, vt[i].en, vt[i].ack,
           mk(vt[i].e_line, vt[i].e_phase, vt[i].e_irq_n, vt[i].e_fs),
           $sformatf("vec%0d", i));
    end
    h_end = 1'b0; int_en = 1'b0; int_ack = 1'b0;

    // Asynchronous reset mid-cycle at line 491 with interrupt pending.
    do_reset();
    advance(491, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", mk(0, 0, 1'b1, 1'b0));
    #2;
    h_end = 1'b1;
    reset_n = 1'b1;
    sb_q.push_back(mk(0, 0, 1'b1, 1'b0));
    tick();
    sb_pop("rst_first_edge");
    sb_q.push_back(mk(1, 0, 1'b1, 1'b0));
    tick();
    sb_pop("after_reset");
    h_end = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
